// File: rtl/textvram_scroll.sv
// Text VRAM with a CPU access port and a display fetch port, plus hardware screen clear
// and one-row scroll-up implemented by rotating a circular row base.
module textvram_scroll #(
  parameter int unsigned        COLS   = 80,
  parameter int unsigned        ROWS   = 30,
  parameter int unsigned        ADDR_W = 12,
  parameter int unsigned        DATA_W = 8,
  parameter logic [DATA_W-1:0]  FILL   = DATA_W'(8'h20),
  localparam int unsigned       TR_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              clear_start,
  input  logic              scroll_up,
  output logic              busy,
  output logic [TR_W-1:0]   top_row
);

  localparam int unsigned       DEPTH   = COLS * ROWS;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COLS_X  = (ADDR_W+1)'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] COLS_M1 = ADDR_W'(COLS - 1);
  localparam logic [TR_W-1:0]   ROWS_M1 = TR_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   fill_addr, fill_addr_n;
  logic [ADDR_W-1:0]   fill_last, fill_last_n;
  logic [ADDR_W-1:0]   row_base, row_base_n;
  logic [TR_W-1:0]     top_row_n;
  logic                busy_n;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W:0]     rb_inc_c;
  logic [ADDR_W-1:0]   cpu_phys_c, disp_phys_c;
  logic                cpu_oor_c, disp_oor_c, accept_c;
  logic                wr_en_c;
  logic [ADDR_W-1:0]   wr_addr_c;
  logic [DATA_W-1:0]   wr_data_c;

  // Logical-to-physical translation through the circular row base.
  function automatic logic [ADDR_W-1:0] xlate(input logic [ADDR_W-1:0] la,
                                              input logic [ADDR_W-1:0] base);
    logic [ADDR_W:0] s;
    s = {1'b0, la} + {1'b0, base};
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[ADDR_W-1:0];
  endfunction

  assign cpu_phys_c  = xlate(cpu_addr, row_base);
  assign disp_phys_c = xlate(disp_addr, row_base);
  assign cpu_oor_c   = ({1'b0, cpu_addr} >= DEPTH_X);
  assign disp_oor_c  = ({1'b0, disp_addr} >= DEPTH_X);
  assign rb_inc_c    = {1'b0, row_base} + COLS_X;
  assign accept_c    = (state == S_IDLE) && cpu_req && !cpu_ack && !clear_start && !scroll_up;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      fill_addr <= '0;
      fill_last <= '0;
      row_base  <= '0;
      top_row   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      fill_addr <= fill_addr_n;
      fill_last <= fill_last_n;
      row_base  <= row_base_n;
      top_row   <= top_row_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    fill_addr_n = fill_addr;
    fill_last_n = fill_last;
    row_base_n  = row_base;
    top_row_n   = top_row;
    busy_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_start) begin
          state_n     = S_CLEAR;
          fill_addr_n = '0;
          fill_last_n = LAST_A;
          row_base_n  = '0;
          top_row_n   = '0;
        end else if (scroll_up) begin
          // Old top row becomes the new bottom row and is blanked in place.
          state_n     = S_SCROLL;
          fill_addr_n = row_base;
          fill_last_n = row_base + COLS_M1;
          row_base_n  = (rb_inc_c >= DEPTH_X) ? '0 : rb_inc_c[ADDR_W-1:0];
          top_row_n   = (top_row == ROWS_M1) ? '0 : top_row + TR_W'(1);
        end
      end
      S_CLEAR, S_SCROLL: begin
        fill_addr_n = fill_addr + ADDR_W'(1);
        if (fill_addr == fill_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // Port A: fill engine owns the write port while busy, otherwise accepted CPU writes.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = fill_addr;
    wr_data_c = FILL;
    if (state != S_IDLE) begin
      wr_en_c = 1'b1;
    end else if (accept_c && cpu_we && !cpu_oor_c) begin
      wr_en_c   = 1'b1;
      wr_addr_c = cpu_phys_c;
      wr_data_c = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_c] <= wr_data_c;
  end

  // Registered read ports; display read sees pre-write data on a same-cell collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      disp_rdata <= '0;
    end else begin
      cpu_ack <= accept_c;
      if (accept_c && !cpu_we) cpu_rdata <= cpu_oor_c ? FILL : mem[cpu_phys_c];
      disp_rdata <= disp_oor_c ? FILL : mem[disp_phys_c];
    end
  end

endmodule

// File: tb/tb_textvram_scroll.sv
// Self-checking bench for textvram_scroll: vector table, corner-case sequences and a
// randomized phase checked against a logical-screen model that shifts rows on scroll.
module tb_textvram_scroll;

  localparam int   COLS  = 80;
  localparam int   ROWS  = 30;
  localparam int   DEPTH = COLS * ROWS;
  localparam logic [7:0] FILL = 8'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [11:0] cpu_addr, disp_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, disp_rdata;
  logic        clear_start, scroll_up, busy;
  logic [4:0]  top_row;

  always #5 clk = ~clk;

  textvram_scroll #(.COLS(80), .ROWS(30), .ADDR_W(12), .DATA_W(8), .FILL(8'h20)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .disp_addr(disp_addr), .disp_rdata(disp_rdata),
    .clear_start(clear_start), .scroll_up(scroll_up),
    .busy(busy), .top_row(top_row)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the screen as seen logically, row 0 on top.
  logic [7:0] screen [DEPTH];
  int         top_m = 0;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) screen[i] = FILL;
    top_m = 0;
  endfunction

  function automatic void m_scroll();
    for (int i = 0; i < DEPTH - COLS; i++) screen[i] = screen[i + COLS];
    for (int i = DEPTH - COLS; i < DEPTH; i++) screen[i] = FILL;
    top_m = (top_m + 1) % ROWS;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    return (a < DEPTH) ? screen[a] : FILL;
  endfunction

  function automatic void m_write(input int a, input logic [7:0] d);
    if (a < DEPTH) screen[a] = d;
  endfunction

  // One CPU access; lat counts cycles from request to ack, with a trailing idle cycle.
  task automatic cpu_xfer(input logic we, input int a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = 12'(a); cpu_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ack && lat < 5000);
    rd = cpu_rdata;
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic disp_read(input int a, output logic [7:0] d);
    disp_addr = 12'(a);
    @(negedge clk);
    d = disp_rdata;
  endtask

  // Pulse clear/scroll and count busy cycles; optional scroll injection and early stop.
  task automatic pulse_count(input logic clr, input logic scr, input int inj_at,
                             input int stop_at, output int n, output logic ack_seen);
    clear_start = clr; scroll_up = scr;
    @(negedge clk);
    clear_start = 1'b0; scroll_up = 1'b0;
    n = 0; ack_seen = 1'b0;
    while (busy && n < 5000 && n != stop_at) begin
      if (cpu_ack) ack_seen = 1'b1;
      scroll_up = (n == inj_at);
      n++;
      @(negedge clk);
    end
    scroll_up = 1'b0;
  endtask

  initial begin
    vec_t       vecs [8];
    logic [7:0] rd;
    int         lat, n, a, op;
    logic       ack_seen;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_addr = '0; clear_start = 1'b0; scroll_up = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", int'(cpu_ack), 0);
    check("rst_cpu_rdata", int'(cpu_rdata), 0);
    check("rst_disp_rdata", int'(disp_rdata), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_top_row", int'(top_row), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic accesses, including out-of-range write/read.
    vecs[0] = '{1'b1, 12'd0,    8'h41, 8'h00};
    vecs[1] = '{1'b1, 12'd2399, 8'h42, 8'h00};
    vecs[2] = '{1'b0, 12'd0,    8'h00, 8'h41};
    vecs[3] = '{1'b0, 12'd2399, 8'h00, 8'h42};
    vecs[4] = '{1'b1, 12'd4000, 8'h77, 8'h00};
    vecs[5] = '{1'b0, 12'd4000, 8'h00, 8'h20};
    vecs[6] = '{1'b0, 12'd2400, 8'h00, 8'h20};
    vecs[7] = '{1'b0, 12'd0,    8'h00, 8'h41};
    for (int i = 0; i < 8; i++) begin
      cpu_xfer(vecs[i].we, int'(vecs[i].addr), vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d_latency", i), lat, 1);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), int'(rd), int'(vecs[i].exp));
    end
    disp_read(2399, rd);
    check("disp_2399", int'(rd), 8'h42);
    disp_read(4095, rd);
    check("disp_oor", int'(rd), 8'h20);
    check("top_row_t1", int'(top_row), 0);

    // Same-cell CPU write and display read: display sees old data.
    disp_addr = 12'd0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd0; cpu_wdata = 8'h99;
    @(negedge clk);
    check("rf_ack", int'(cpu_ack), 1);
    check("rf_old", int'(disp_rdata), 8'h41);
    cpu_req = 1'b0;
    @(negedge clk);
    check("rf_new", int'(disp_rdata), 8'h99);
    check("rf_ack_pulse", int'(cpu_ack), 0);

    // Clear with a read request held pending.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd7;
    pulse_count(1'b1, 1'b0, -1, -1, n, ack_seen);
    m_clear();
    check("clear_busy_cycles", n, DEPTH);
    check("clear_no_ack_busy", int'(ack_seen), 0);
    check("clear_ack_at_fall", int'(cpu_ack), 0);
    @(negedge clk);
    check("clear_ack_after", int'(cpu_ack), 1);
    check("clear_pending_rdata", int'(cpu_rdata), 8'h20);
    cpu_req = 1'b0;
    @(negedge clk);
    check("clear_top_row", int'(top_row), 0);
    for (int i = 0; i < DEPTH; i += 37) begin
      disp_read(i, rd);
      check($sformatf("clear_disp_%0d", i), int'(rd), int'(m_read(i)));
    end

    // Row markers then one scroll.
    for (int r = 0; r < ROWS; r++) begin
      cpu_xfer(1'b1, r * COLS, 8'(8'h30 + r), rd, lat);
      m_write(r * COLS, 8'(8'h30 + r));
    end
    pulse_count(1'b0, 1'b1, -1, -1, n, ack_seen);
    m_scroll();
    check("scroll_busy_cycles", n, COLS);
    check("scroll_top_row", int'(top_row), 1);
    cpu_xfer(1'b0, 0, 8'h00, rd, lat);
    check("scroll_log0", int'(rd), 8'h31);
    cpu_xfer(1'b0, 2320, 8'h00, rd, lat);
    check("scroll_log2320", int'(rd), 8'h20);
    disp_read(COLS, rd);
    check("scroll_disp_row1", int'(rd), int'(m_read(COLS)));

    // Fresh clear, then 30 scrolls: top_row wraps back to 0.
    pulse_count(1'b1, 1'b0, -1, -1, n, ack_seen);
    m_clear();
    for (int r = 0; r < ROWS; r++) begin
      cpu_xfer(1'b1, r * COLS + 5, 8'(8'h60 + r), rd, lat);
      m_write(r * COLS + 5, 8'(8'h60 + r));
    end
    for (int k = 0; k < ROWS; k++) begin
      pulse_count(1'b0, 1'b1, -1, -1, n, ack_seen);
      m_scroll();
      check($sformatf("wrap_top_row_%0d", k), int'(top_row), top_m);
    end
    for (int k = 0; k < 24; k++) begin
      cpu_xfer(1'b1, k * 97, 8'(8'hA0 + k), rd, lat);
      m_write(k * 97, 8'(8'hA0 + k));
    end
    for (int k = 0; k < 24; k++) begin
      disp_read(k * 97, rd);
      check($sformatf("ident_disp_%0d", k), int'(rd), int'(m_read(k * 97)));
      disp_read(k * 97 + 5, rd);
      check($sformatf("ident_blank_%0d", k), int'(rd), int'(m_read(k * 97 + 5)));
    end

    // Randomized mix against the model.
    for (int s = 0; s < 300; s++) begin
      op = int'($urandom_range(0, 19));
      a  = int'($urandom_range(0, 2599));
      if (op < 8) begin
        rd = 8'($urandom);
        cpu_xfer(1'b1, a, rd, rd, lat);
        m_write(a, 8'(cpu_wdata));
        check($sformatf("rnd_wlat_%0d", s), lat, 1);
      end else if (op < 13) begin
        cpu_xfer(1'b0, a, 8'h00, rd, lat);
        check($sformatf("rnd_cpu_%0d_a%0d", s, a), int'(rd), int'(m_read(a)));
      end else if (op < 18) begin
        disp_read(a, rd);
        check($sformatf("rnd_disp_%0d_a%0d", s, a), int'(rd), int'(m_read(a)));
      end else begin
        pulse_count(1'b0, 1'b1, -1, -1, n, ack_seen);
        m_scroll();
        check($sformatf("rnd_scroll_busy_%0d", s), n, COLS);
        check($sformatf("rnd_scroll_top_%0d", s), int'(top_row), top_m);
      end
    end

    // Clear and scroll in the same cycle, plus a scroll during busy: both scrolls dropped.
    pulse_count(1'b0, 1'b1, -1, -1, n, ack_seen);
    m_scroll();
    pulse_count(1'b1, 1'b1, 100, -1, n, ack_seen);
    m_clear();
    check("both_busy_cycles", n, DEPTH);
    check("both_top_row", int'(top_row), 0);
    @(negedge clk);
    check("both_idle_after", int'(busy), 0);
    disp_read(1500, rd);
    check("both_disp", int'(rd), 8'h20);

    // Reset in the middle of a clear.
    for (int i = 0; i < 600; i++) cpu_xfer(1'b1, i, 8'h55, rd, lat);
    pulse_count(1'b1, 1'b0, -1, 500, n, ack_seen);
    check("mid_busy_count", n, 500);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ack", int'(cpu_ack), 0);
    check("mid_rst_top", int'(top_row), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_idle", int'(busy), 0);
    for (int i = 0; i < 480; i += 53) begin
      disp_read(i, rd);
      check($sformatf("mid_filled_%0d", i), int'(rd), 8'h20);
    end
    for (int i = 530; i < 600; i += 13) begin
      disp_read(i, rd);
      check($sformatf("mid_kept_%0d", i), int'(rd), 8'h55);
    end
    pulse_count(1'b1, 1'b0, -1, -1, n, ack_seen);
    m_clear();
    check("post_clear_busy", n, DEPTH);
    for (int i = 0; i < 600; i += 61) begin
      cpu_xfer(1'b0, i, 8'h00, rd, lat);
      check($sformatf("post_clear_cpu_%0d", i), int'(rd), int'(m_read(i)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/textvram_scroll.md
Name: textvram_scroll

Overview:
- Parametrised single-clock text VRAM: a character/attribute store with a CPU access port and a display fetch port.
- Adds hardware screen clear and hardware one-row scroll-up, implemented as a circular row base.
- Sits between the CPU bus bridge and the text display pipeline, in place of a fixed 4096x8 dual-port text store.
- Memory is an inferred true dual-port RAM: port A is CPU/fill writes, port B is display reads.

Parameters:
- COLS, 80: characters per row.
- ROWS, 30: rows per screen. DEPTH = COLS*ROWS, and DEPTH must be <= 2**ADDR_W.
- ADDR_W, 12: logical address width.
- DATA_W, 8: cell width.
- FILL, 8'h20: value written by clear and scroll (ASCII space).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous reset, active-high.
- cpu_req, in, 1: access request; held high until cpu_ack.
- cpu_we, in, 1: 1 = write, 0 = read.
- cpu_addr, in, ADDR_W: logical cell address, row*COLS+col.
- cpu_wdata, in, DATA_W: write data.
- cpu_ack, out, 1: one-cycle completion pulse.
- cpu_rdata, out, DATA_W: read data, valid while cpu_ack is high.
- disp_addr, in, ADDR_W: logical display fetch address.
- disp_rdata, out, DATA_W: data for disp_addr, one cycle later.
- clear_start, in, 1: pulse to fill the whole screen and reset scroll.
- scroll_up, in, 1: pulse to scroll up one row.
- busy, out, 1: clear or scroll in progress.
- top_row, out, clog2(ROWS): current physical row shown as logical row 0.

Behaviour:
- Reset values: cpu_ack=0, cpu_rdata=0, disp_rdata=0, busy=0, top_row=0, row_base=0, FSM=IDLE.
  - RAM contents are not reset.
  - A reset mid-clear or mid-scroll aborts the operation immediately; cells already filled stay filled.
- Address translation, shared by both ports:
  - row_base = top_row*COLS, held as a register and updated by adding COLS, never by multiplying.
  - phys = logical + row_base, computed at ADDR_W+1 bits; if phys >= DEPTH, subtract DEPTH.
- FSM states: IDLE, CLEAR, SCROLL. Priority in IDLE is clear_start > scroll_up > cpu_req.
- IDLE + clear_start:
  - Go to CLEAR; fill counter = 0; top_row and row_base = 0.
  - busy goes high the next cycle.
- CLEAR:
  - Each cycle writes FILL to physical address counter, then increments the counter.
  - After the write at DEPTH-1, go to IDLE; busy falls the same edge.
  - Total duration: exactly DEPTH busy cycles.
- IDLE + scroll_up (no clear_start):
  - Target = old row_base.
  - top_row increments (ROWS-1 wraps to 0); row_base += COLS, wrapping to 0 at DEPTH.
  - Go to SCROLL.
- SCROLL:
  - Writes FILL to target+0 .. target+COLS-1, one per cycle, which blanks the new bottom row.
  - Busy for exactly COLS cycles, then IDLE.
- clear_start or scroll_up while busy: ignored, with no queuing.
- CPU handshake:
  - A request is accepted in IDLE when cpu_req=1, cpu_ack=0, and no clear/scroll is starting that cycle.
  - cpu_ack pulses exactly one cycle after acceptance.
  - Writes are committed at the acceptance edge.
  - Read data comes from the acceptance-cycle address and is presented with cpu_ack.
  - cpu_req still high during the ack cycle is not re-accepted, so maximum throughput is one access per 2 cycles.
  - While busy, requests stall with cpu_ack=0.
- cpu_addr >= DEPTH: a write is dropped, a read returns FILL; ack is still issued.
- Display port:
  - Never stalls; it reads during busy and may see partially filled data.
  - disp_rdata = RAM[phys(disp_addr)] registered, 1-cycle latency.
  - disp_addr >= DEPTH returns FILL.
  - Translation uses row_base as of the fetch cycle.
- CPU write and display read of the same physical cell in the same cycle: display returns old data (read-first).
- cpu_rdata and disp_rdata hold their values between accesses.

Test Plan (COLS=80, ROWS=30, DEPTH=2400, FILL=8'h20):
- Reset, write 0x41 at logical 0 and 0x42 at logical 2399, then read both.
  - Required: ack one cycle after each acceptance; rdata 0x41 and 0x42.
  - Required: disp_addr=2399 returns 0x42 one cycle later.
- clear_start with cpu_req held high.
  - Required: busy high for exactly 2400 cycles and cpu_ack stays 0 throughout.
  - Required: the pending request is acked 1 cycle after busy falls.
  - Required: all display reads after the clear return 0x20; top_row=0.
- Write row r value 0x30+r at col 0 for r=0..29, then pulse scroll_up.
  - Required: top_row=1 and busy high for 80 cycles.
  - Required: logical 0 reads 0x31 and logical 2320 reads 0x20.
- Scroll 30 times.
  - Required: top_row wraps 29->0; row_base returns to 0.
  - Required: a logical/physical identity check passes.
- clear_start and scroll_up in the same cycle: clear runs (2400 busy cycles), scroll dropped, top_row=0. A scroll_up during busy is likewise ignored.
- Assert rst at cycle 500 of a clear.
  - Required: busy=0, cpu_ack=0, top_row=0 immediately.
  - Required: cells 0..~499 read 0x20; a later clear completes normally.
